// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry pipeline register with skid buffer for a fetch/decode
// style payload (pc, instr, exception code, branch-delay flag, branch judge).
// in_ready comes straight from a flop, so there is no combinational path from
// out_ready back to the upstream stage. An exception redirect (req) loads the
// handler PC into the main entry as an invalid bubble; flush clears everything.
//
// Ports:
//   clk, reset (async, active-low)
//   flush, req                        : synchronous clear / exception redirect
//   in_valid/in_ready + in_* payload  : upstream handshake
//   out_valid/out_ready + out_* payload: downstream handshake (main entry flops)
//   occupancy                         : number of valid entries held (0..2)
module pipe_skid_reg #(
  parameter int unsigned     PC_W       = 32,
  parameter int unsigned     INSTR_W    = 32,
  parameter int unsigned     EXC_W      = 5,
  parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(32'h0000_4180)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               req,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  input  logic               in_bjudge,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bd,
  output logic               out_bjudge,
  output logic [1:0]         occupancy
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [EXC_W-1:0]   exc;
    logic               bd;
    logic               bjudge;
  } entry_t;

  // EMPTY: nothing held; ONE: main valid; FULL: main and skid valid.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  logic       out_valid_q, out_valid_d;
  logic       in_ready_q, in_ready_d;
  logic [1:0] occ_q, occ_d;

  entry_t in_entry;
  entry_t handler_entry;
  logic   up_xfer;
  logic   dn_xfer;

  assign in_entry = '{pc: in_pc, instr: in_instr, exc: in_exc,
                      bd: in_bd, bjudge: in_bjudge};

  // Bubble loaded on an exception redirect: handler PC, everything else zero.
  assign handler_entry = '{pc: HANDLER_PC, instr: '0, exc: '0,
                           bd: 1'b0, bjudge: 1'b0};

  assign up_xfer = in_valid & in_ready_q;
  assign dn_xfer = out_valid_q & out_ready;

  // Next-state and next-payload logic; req beats flush beats handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (req) begin
      state_d = S_EMPTY;
      main_d  = handler_entry;
    end else if (flush) begin
      state_d = S_EMPTY;
      main_d  = '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (up_xfer) begin
            main_d  = in_entry;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (up_xfer && dn_xfer) begin
            main_d = in_entry;
          end else if (up_xfer) begin
            skid_d  = in_entry;
            state_d = S_FULL;
          end else if (dn_xfer) begin
            // Main payload is left as-is; it is simply marked invalid.
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (dn_xfer) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  // Registered status outputs are precomputed from the next state.
  always_comb begin
    out_valid_d = 1'b0;
    in_ready_d  = 1'b1;
    occ_d       = 2'd0;
    unique case (state_d)
      S_ONE: begin
        out_valid_d = 1'b1;
        occ_d       = 2'd1;
      end
      S_FULL: begin
        out_valid_d = 1'b1;
        in_ready_d  = 1'b0;
        occ_d       = 2'd2;
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        occ_d       = 2'd0;
      end
    endcase
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      occ_q       <= occ_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign occupancy  = occ_q;
  assign out_pc     = main_q.pc;
  assign out_instr  = main_q.instr;
  assign out_exc    = main_q.exc;
  assign out_bd     = main_q.bd;
  assign out_bjudge = main_q.bjudge;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized checks for pipe_skid_reg.
module tb_pipe_skid_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        req;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [4:0]  in_exc;
  logic        in_bd;
  logic        in_bjudge;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_exc;
  logic        out_bd;
  logic        out_bjudge;
  logic [1:0]  occupancy;

  int n_pass;
  int n_total;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
    logic        bjudge;
  } item_t;

  pipe_skid_reg dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req        (req),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .in_exc     (in_exc),
    .in_bd      (in_bd),
    .in_bjudge  (in_bjudge),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_exc    (out_exc),
    .out_bd     (out_bd),
    .out_bjudge (out_bjudge),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    in_exc   = 5'h3;
    in_bd    = 1'b1;
    in_bjudge = 1'b1;
  endtask

  task automatic check_status(input string name, input logic ev, input logic er,
                              input logic [1:0] eo);
    n_total++;
    if (out_valid !== ev || in_ready !== er || occupancy !== eo)
      $display("FAIL %s: valid/ready/occ got %b/%b/%0d exp %b/%b/%0d",
               name, out_valid, in_ready, occupancy, ev, er, eo);
    else n_pass++;
  endtask

  task automatic check_pc(input string name, input logic [31:0] exp);
    n_total++;
    if (out_pc !== exp) $display("FAIL %s: out_pc got %h exp %h", name, out_pc, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; req = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0; in_exc = '0; in_bd = 1'b0; in_bjudge = 1'b0;
    #12;
    check_status("reset_initial", 1'b0, 1'b1, 2'd0);
    check_pc("reset_initial_pc", 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    // Load an item, then drop reset mid-cycle with no clock edge in between.
    push(32'h0000_1234, 32'hdead_beef);
    tick();
    in_valid = 1'b0;
    check_status("reset_loaded", 1'b1, 1'b1, 2'd1);
    check_pc("reset_loaded_pc", 32'h0000_1234);
    #2;
    reset = 1'b0;
    #1;
    check_status("reset_async", 1'b0, 1'b1, 2'd0);
    check_pc("reset_async_pc", 32'h0);
    n_total++;
    if (out_instr !== 32'h0 || out_exc !== 5'h0 || out_bd !== 1'b0 || out_bjudge !== 1'b0)
      $display("FAIL reset_async_payload: got %h %h %b %b exp 0", out_instr, out_exc, out_bd, out_bjudge);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3];
    pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(pcs[i], 32'h100 + 32'(i));
      tick();
      check_pc($sformatf("stream_pc%0d", i), pcs[i]);
      check_status($sformatf("stream_st%0d", i), 1'b1, 1'b1, 2'd1);
    end
    in_valid = 1'b0;
    tick();
    check_status("stream_drain", 1'b0, 1'b1, 2'd0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(32'h3000, 32'h1);
    tick();
    check_status("bp_one", 1'b1, 1'b1, 2'd1);
    push(32'h3004, 32'h2);
    tick();
    check_status("bp_full", 1'b1, 1'b0, 2'd2);
    check_pc("bp_full_pc", 32'h3000);
    push(32'h3008, 32'h3);
    tick();
    check_status("bp_held", 1'b1, 1'b0, 2'd2);
    check_pc("bp_held_pc", 32'h3000);
    out_ready = 1'b1;
    tick();
    check_pc("bp_out2", 32'h3004);
    check_status("bp_after_pop", 1'b1, 1'b1, 2'd1);
    n_total++;
    if (out_instr !== 32'h2) $display("FAIL bp_out2_instr: got %h exp %h", out_instr, 32'h2);
    else n_pass++;
    tick();
    check_pc("bp_out3", 32'h3008);
    in_valid = 1'b0;
    tick();
    check_status("bp_drain", 1'b0, 1'b1, 2'd0);
  endtask

  task automatic test_exception();
    out_ready = 1'b0;
    push(32'h3000, 32'haa);
    tick();
    push(32'h3004, 32'hbb);
    tick();
    check_status("exc_full", 1'b1, 1'b0, 2'd2);
    req = 1'b1;
    push(32'h5000, 32'hcc);
    tick();
    req = 1'b0;
    in_valid = 1'b0;
    check_pc("exc_pc", 32'h0000_4180);
    check_status("exc_st", 1'b0, 1'b1, 2'd0);
    n_total++;
    if (out_instr !== 32'h0 || out_exc !== 5'h0 || out_bd !== 1'b0 || out_bjudge !== 1'b0)
      $display("FAIL exc_payload: got %h %h %b %b exp 0", out_instr, out_exc, out_bd, out_bjudge);
    else n_pass++;
    // The discarded skid entry must not resurface.
    out_ready = 1'b1;
    tick();
    check_status("exc_no_ghost", 1'b0, 1'b1, 2'd0);
    push(32'h3100, 32'h11);
    tick();
    in_valid = 1'b0;
    check_pc("exc_resume_pc", 32'h3100);
    check_status("exc_resume", 1'b1, 1'b1, 2'd1);
    tick();
  endtask

  task automatic test_flush_priority();
    out_ready = 1'b0;
    push(32'h3200, 32'h22);
    tick();
    req = 1'b1;
    flush = 1'b1;
    tick();
    req = 1'b0;
    flush = 1'b0;
    check_pc("prio_req_pc", 32'h0000_4180);
    check_status("prio_req_st", 1'b0, 1'b1, 2'd0);
    push(32'h3300, 32'h33);
    tick();
    push(32'h3304, 32'h34);
    tick();
    check_status("flush_full", 1'b1, 1'b0, 2'd2);
    flush = 1'b1;
    push(32'h3308, 32'h35);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_pc("flush_pc", 32'h0);
    check_status("flush_st", 1'b0, 1'b1, 2'd0);
    n_total++;
    if (out_instr !== 32'h0) $display("FAIL flush_instr: got %h exp 0", out_instr);
    else n_pass++;
  endtask

  task automatic test_random();
    item_t q[$];
    item_t cur;
    item_t obs;
    logic  exp_valid, exp_ready, up, dn, ok;
    flush = 1'b1;
    in_valid = 1'b0;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      exp_valid = (q.size() > 0);
      exp_ready = (q.size() < 2);
      obs = '{out_pc, out_instr, out_exc, out_bd, out_bjudge};
      ok = (out_valid === exp_valid) && (in_ready === exp_ready) &&
           (occupancy === 2'(q.size()));
      if (exp_valid && obs !== q[0]) ok = 1'b0;
      n_total++;
      if (!ok)
        $display("FAIL rand_cycle%0d: v/r/occ %b/%b/%0d pc %h exp %b/%b/%0d pc %h",
                 c, out_valid, in_ready, occupancy, out_pc, exp_valid, exp_ready,
                 q.size(), exp_valid ? q[0].pc : 32'h0);
      else n_pass++;
      cur.pc = $urandom; cur.instr = $urandom; cur.exc = 5'($urandom);
      cur.bd = 1'($urandom); cur.bjudge = 1'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 19) == 0);
      in_pc = cur.pc; in_instr = cur.instr; in_exc = cur.exc;
      in_bd = cur.bd; in_bjudge = cur.bjudge;
      up = in_valid && exp_ready;
      dn = exp_valid && out_ready;
      tick();
      if (flush) q.delete();
      else begin
        if (dn) void'(q.pop_front());
        if (up) q.push_back(cur);
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_exception();
    test_flush_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter PC_W, default 32: PC field width.
REQ-002 Parameter INSTR_W, default 32: instruction field width.
REQ-003 Parameter EXC_W, default 5: exception-code field width.
REQ-004 Parameter HANDLER_PC, default 32'h0000_4180: PC value loaded on exception request.
REQ-005 clk  in  1: single clock, all state on rising edge.
REQ-006 reset  in  1: asynchronous, active-low (0 = reset asserted).
REQ-007 flush  in  1: synchronous clear of all entries, branch-mispredict/stall bubble.
REQ-008 req  in  1: synchronous exception/interrupt redirect.
REQ-009 in_valid  in  1 / in_ready  out  1: upstream handshake.
REQ-010 in_pc  in  PC_W; in_instr  in  INSTR_W; in_exc  in  EXC_W; in_bd  in  1; in_bjudge  in  1: upstream payload.
REQ-011 out_valid  out  1 / out_ready  in  1: downstream handshake.
REQ-012 out_pc, out_instr, out_exc, out_bd, out_bjudge  out: downstream payload, same widths as inputs.
REQ-013 occupancy  out  2: number of valid entries held (0..2).

Function
REQ-014 Two storage entries SHALL exist: main (drives out_*) and skid (overflow).
REQ-015 in_ready SHALL equal NOT skid_valid, driven from a register, with no combinational path from out_ready.
REQ-016 Upstream transfer SHALL occur when in_valid AND in_ready at a rising edge; downstream transfer when out_valid AND out_ready.
REQ-017 out_valid SHALL equal main_valid; out_* SHALL be the main entry fields directly from flops.
REQ-018 State EMPTY (main and skid invalid): upstream transfer loads main; next state ONE.
REQ-019 State ONE, downstream transfer without upstream transfer: main invalidated; next EMPTY.
REQ-020 State ONE, upstream transfer with downstream transfer: main reloaded from input; stay ONE.
REQ-021 State ONE, upstream transfer without downstream transfer: input captured in skid; next FULL.
REQ-022 State FULL (in_ready=0): downstream transfer moves skid into main, skid invalidated; next ONE; otherwise hold.
REQ-023 Entry ordering SHALL be preserved: no item dropped, duplicated or reordered.
REQ-024 Single-item latency SHALL be 1 cycle: accepted at edge N, out_valid high after edge N.
REQ-025 Sustained throughput SHALL be one item per cycle while out_ready stays high.
REQ-026 req=1 at an edge SHALL invalidate skid and load main with pc=HANDLER_PC, instr=0, exc=0, bd=0, bjudge=0, valid=0; any concurrent upstream transfer is discarded.
REQ-027 flush=1 (req=0) at an edge SHALL invalidate both entries and zero all main payload fields; any concurrent upstream transfer is discarded.
REQ-028 Priority SHALL be reset > req > flush > handshake.
REQ-029 in_ready SHALL be 1 in the cycle after any req or flush.
REQ-030 Payload of an invalid entry SHALL NOT change except by req, flush or reset.
REQ-031 occupancy SHALL equal main_valid + skid_valid, registered.

Reset
REQ-032 reset=0 SHALL immediately, without clock, clear main_valid, skid_valid and all payload to 0; out_pc=0, in_ready=1, occupancy=0.
REQ-033 Release SHALL be used synchronously; first transfer may occur on the first edge with reset=1.
REQ-034 reset asserted mid-transfer SHALL discard both entries; no partial payload visible.

Verification
REQ-035 Reset: reset=0 asynchronously mid-cycle -> out_valid=0, out_pc=0, in_ready=1, occupancy=0 before next edge.
REQ-036 Streaming: out_ready=1, push pc 0x3000,0x3004,0x3008 back-to-back -> same pcs on out_pc edges 1,2,3; occupancy stays 1.
REQ-037 Backpressure: out_ready=0, push 0x3000, 0x3004 -> occupancy=2, in_ready=0; third push held; out_ready=1 -> 0x3000 then 0x3004 emitted in order.
REQ-038 Exception: FULL state, req=1 with in_valid=1 -> next cycle out_pc=0x4180, out_instr=0, out_valid=0, occupancy=0, in_ready=1.
REQ-039 Flush priority: req=1 and flush=1 same edge -> out_pc=0x4180; flush alone -> out_pc=0, out_valid=0.
REQ-040 Random: random in_valid/out_ready/flush for 10k cycles against scoreboard -> no loss/duplication, in_ready never low with occupancy<2.
